// File: rtl/uart_echo_agent_if.sv
// Handshake and serial bundle between the echo agent and its host bench.
interface uart_echo_agent_if;
    logic        start;
    logic        serial_out;
    logic        serial_in;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [15:0] mismatch_count;
    logic        recv_valid;
    logic [7:0]  recv_data;

    modport master (
        output start, serial_in,
        input  serial_out, busy, done, pass, timeout,
        input  mismatch_count, recv_valid, recv_data
    );

    modport slave (
        input  start, serial_in,
        output serial_out, busy, done, pass, timeout,
        output mismatch_count, recv_valid, recv_data
    );
endinterface

// File: rtl/uart_echo_agent.sv
// Host-side UART agent: streams CHAR0+i to a device, checks the echoes
// through a bounded expected-character FIFO, reports pass/fail/timeout.
module uart_echo_agent #(
    parameter int unsigned CLOCK_FREQ     = 50_000_000,
    parameter int unsigned BAUD_RATE      = 115_200,
    parameter int unsigned NUM_CHARS      = 10,
    parameter logic [7:0]  CHAR0          = 8'h61,
    parameter int unsigned INFLIGHT       = 4,
    parameter int unsigned GAP_BITS       = 0,
    parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
    input logic clk,
    input logic rst,
    uart_echo_agent_if.slave bus
);
    localparam int unsigned B   = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned HB  = B / 2;
    localparam int unsigned GAP = GAP_BITS * B;
    localparam int unsigned AW  = (INFLIGHT > 1) ? $clog2(INFLIGHT) : 1;
    localparam int unsigned CW  = $clog2(INFLIGHT + 1);
    localparam logic [CW-1:0] FULL = CW'(INFLIGHT);
    localparam logic [15:0]   NCH  = 16'(NUM_CHARS);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_GAP
    } tx_e;
    typedef enum logic [1:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP
    } rx_e;

    tx_e         tx_st_q;
    rx_e         rx_st_q;
    logic [31:0] tx_cnt_q, rx_cnt_q, to_cnt_q;
    logic [2:0]  tx_bit_q, rx_bit_q;
    logic [7:0]  tx_sh_q, rx_sh_q;
    logic [15:0] tx_idx_q, rx_idx_q, mm_q;
    logic        so_q, s1_q, s2_q;
    logic        busy_q, done_q, pass_q, timeout_q, rv_q;
    logic [7:0]  rd_q;
    logic [7:0]  mem_q [INFLIGHT];
    logic [AW-1:0] wp_q, rp_q;
    logic [CW-1:0] cnt_q;

    logic        fifo_full, fifo_empty, push, pop, bad;
    logic        rx_done, tx_end, abort;
    logic [7:0]  tx_char;
    logic [15:0] mm_d;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (32'(p) == INFLIGHT - 1) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        fifo_full  = (cnt_q == FULL);
        fifo_empty = (cnt_q == '0);
        tx_char    = CHAR0 + tx_idx_q[7:0];
        push = busy_q && (tx_st_q == TX_IDLE)
            && (tx_idx_q < NCH) && !fifo_full;
        tx_end = (tx_st_q == TX_GAP) ? (tx_cnt_q == GAP - 1)
                                     : (tx_cnt_q == B - 1);
        rx_done = (rx_st_q == RX_STOP) && (rx_cnt_q == B - 1);
        pop = rx_done && busy_q && !fifo_empty;
        // an echo with no outstanding character is always bad
        bad = rx_done && busy_q && (fifo_empty
            || (rx_sh_q != mem_q[rp_q]) || !s2_q);
        mm_d = (mm_q != 16'hFFFF) ? mm_q + 16'd1 : mm_q;
        abort = busy_q && !fifo_empty && !rx_done
            && (to_cnt_q == TIMEOUT_CYCLES - 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_st_q   <= TX_IDLE;
            rx_st_q   <= RX_IDLE;
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            to_cnt_q  <= '0;
            tx_bit_q  <= '0;
            rx_bit_q  <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            tx_idx_q  <= '0;
            rx_idx_q  <= '0;
            mm_q      <= '0;
            so_q      <= 1'b1;
            s1_q      <= 1'b1;
            s2_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            rv_q      <= 1'b0;
            rd_q      <= '0;
            wp_q      <= '0;
            rp_q      <= '0;
            cnt_q     <= '0;
        end else begin
            rv_q <= 1'b0;
            s1_q <= bus.serial_in;
            s2_q <= s1_q;

            if (bus.start && !busy_q) begin
                busy_q    <= 1'b1;
                done_q    <= 1'b0;
                pass_q    <= 1'b0;
                timeout_q <= 1'b0;
                mm_q      <= '0;
                tx_idx_q  <= '0;
                rx_idx_q  <= '0;
            end

            if (tx_st_q != TX_IDLE)
                tx_cnt_q <= tx_end ? '0 : tx_cnt_q + 32'd1;
            unique case (tx_st_q)
                TX_IDLE: if (push) begin
                    tx_st_q  <= TX_START;
                    so_q     <= 1'b0;
                    tx_sh_q  <= tx_char;
                    tx_cnt_q <= '0;
                end
                TX_START: if (tx_end) begin
                    tx_st_q  <= TX_DATA;
                    so_q     <= tx_sh_q[0];
                    tx_sh_q  <= tx_sh_q >> 1;
                    tx_bit_q <= '0;
                end
                TX_DATA: if (tx_end) begin
                    if (tx_bit_q == 3'd7) begin
                        tx_st_q  <= TX_STOP;
                        so_q     <= 1'b1;
                        tx_idx_q <= tx_idx_q + 16'd1;
                    end else begin
                        so_q     <= tx_sh_q[0];
                        tx_sh_q  <= tx_sh_q >> 1;
                        tx_bit_q <= tx_bit_q + 3'd1;
                    end
                end
                TX_STOP: if (tx_end)
                    tx_st_q <= (GAP_BITS == 0) ? TX_IDLE : TX_GAP;
                TX_GAP: if (tx_end)
                    tx_st_q <= TX_IDLE;
                default: tx_st_q <= TX_IDLE;
            endcase

            unique case (rx_st_q)
                RX_IDLE: if (!s2_q) begin
                    rx_st_q  <= RX_START;
                    rx_cnt_q <= '0;
                end
                RX_START: if (rx_cnt_q == HB - 1) begin
                    rx_cnt_q <= '0;
                    rx_bit_q <= '0;
                    rx_st_q  <= s2_q ? RX_IDLE : RX_DATA;
                end else rx_cnt_q <= rx_cnt_q + 32'd1;
                RX_DATA: if (rx_cnt_q == B - 1) begin
                    rx_cnt_q <= '0;
                    rx_sh_q  <= {s2_q, rx_sh_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_st_q <= RX_STOP;
                    else rx_bit_q <= rx_bit_q + 3'd1;
                end else rx_cnt_q <= rx_cnt_q + 32'd1;
                RX_STOP: if (rx_done) begin
                    rx_st_q  <= RX_IDLE;
                    rx_cnt_q <= '0;
                    rv_q     <= 1'b1;
                    rd_q     <= rx_sh_q;
                end else rx_cnt_q <= rx_cnt_q + 32'd1;
                default: rx_st_q <= RX_IDLE;
            endcase

            if (bad) mm_q <= mm_d;
            if (pop) rx_idx_q <= rx_idx_q + 16'd1;
            if (push) begin
                mem_q[wp_q] <= tx_char;
                wp_q <= nxt(wp_q);
            end
            if (pop) rp_q <= nxt(rp_q);
            if (push && !pop) cnt_q <= cnt_q + CW'(1);
            else if (pop && !push) cnt_q <= cnt_q - CW'(1);

            if (!busy_q || fifo_empty || rx_done) to_cnt_q <= '0;
            else to_cnt_q <= to_cnt_q + 32'd1;

            if (busy_q && rx_idx_q == NCH) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
                pass_q <= (mm_q == '0);
            end

            // timeout drops everything in flight, including a partial frame
            if (abort) begin
                busy_q    <= 1'b0;
                done_q    <= 1'b1;
                pass_q    <= 1'b0;
                timeout_q <= 1'b1;
                tx_st_q   <= TX_IDLE;
                rx_st_q   <= RX_IDLE;
                tx_cnt_q  <= '0;
                rx_cnt_q  <= '0;
                to_cnt_q  <= '0;
                so_q      <= 1'b1;
                wp_q      <= '0;
                rp_q      <= '0;
                cnt_q     <= '0;
            end
        end
    end

    assign bus.serial_out     = so_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.timeout        = timeout_q;
    assign bus.mismatch_count = mm_q;
    assign bus.recv_valid     = rv_q;
    assign bus.recv_data      = rd_q;
endmodule

// File: tb/tb_uart_echo_agent.sv
// Bench for uart_echo_agent: loopback, corrupting echo, silent device,
// delayed echo with a small window, glitch rejection and mid-frame reset.
module tb_uart_echo_agent;
    localparam int CF = 160;
    localparam int BR = 10;
    localparam int B  = CF / BR;
    localparam int TO = 2000;
    localparam int DL = 6 * 10 * B;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_echo_agent_if ifa ();
    uart_echo_agent_if ifb ();

    int   mode = 0;
    logic drv_si = 1'b1;
    logic [DL-1:0] dl = '1;

    assign ifa.serial_in = (mode == 1) ? ifa.serial_out : drv_si;
    always @(posedge clk) dl <= {dl[DL-2:0], rst ? 1'b1 : ifb.serial_out};
    assign ifb.serial_in = dl[DL-1];

    uart_echo_agent #(
        .CLOCK_FREQ(CF), .BAUD_RATE(BR), .NUM_CHARS(10),
        .CHAR0(8'h61), .INFLIGHT(4), .GAP_BITS(0),
        .TIMEOUT_CYCLES(TO)
    ) u_a (.clk(clk), .rst(rst), .bus(ifa));

    uart_echo_agent #(
        .CLOCK_FREQ(CF), .BAUD_RATE(BR), .NUM_CHARS(4),
        .CHAR0(8'hFE), .INFLIGHT(2), .GAP_BITS(1),
        .TIMEOUT_CYCLES(TO)
    ) u_b (.clk(clk), .rst(rst), .bus(ifb));

    int total = 0;
    int bad = 0;
    logic [7:0] qa_d[$];
    int         qa_b[$];
    logic [7:0] qb_d[$];
    logic [7:0] got_a[$];
    logic [7:0] got_b[$];
    logic [7:0] txq[$];
    int mm_a = 0;
    int rcv_a = 0;
    int rcv_b = 0;
    int frames_a = 0;
    int frames_b = 0;
    int echo_i = 0;
    logic [15:0] flip_mask = '0;
    logic [15:0] stop_mask = '0;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, act, exp);
        end
    endtask

    function automatic logic so_of(input int w);
        return (w == 0) ? ifa.serial_out : ifb.serial_out;
    endfunction

    // decode one frame from a DUT's serial_out at bit midpoints
    task automatic get_frame(input int w, output logic [7:0] d);
        @(negedge clk);
        while (so_of(w) !== 1'b0) @(negedge clk);
        if (w == 0) frames_a++;
        else begin
            frames_b++;
            chk("b_inflight_le2", 32'((frames_b - rcv_b) <= 2), 1);
        end
        repeat (B / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (B) @(negedge clk);
            d[i] = so_of(w);
        end
        repeat (B) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] c, input logic sb);
        drv_si = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            drv_si = c[i];
            repeat (B) @(negedge clk);
        end
        drv_si = sb;
        repeat (B) @(negedge clk);
        drv_si = 1'b1;
        repeat (2 * B) @(negedge clk);
    endtask

    initial begin : mon_a
        logic [7:0] d;
        forever begin
            get_frame(0, d);
            if (mode == 2) txq.push_back(d);
        end
    end

    initial begin : mon_b
        logic [7:0] d;
        forever get_frame(1, d);
    end

    initial begin : echo_dev
        logic [7:0] c;
        logic sb;
        forever begin
            @(negedge clk);
            if (txq.size() > 0) begin
                c  = txq.pop_front();
                sb = 1'b1;
                if (echo_i < 16 && flip_mask[echo_i]) c = c ^ 8'h01;
                if (echo_i < 16 && stop_mask[echo_i]) sb = 1'b0;
                echo_i++;
                send(c, sb);
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [7:0] d;
        int b;
        if (ifa.recv_valid === 1'b1) begin
            rcv_a++;
            got_a.push_back(ifa.recv_data);
            chk("a_recv_expected", 32'(qa_d.size() > 0), 1);
            if (qa_d.size() > 0) begin
                d = qa_d.pop_front();
                b = qa_b.pop_front();
                if (b != 2) mm_a += b;
                chk("a_recv_data", 32'(ifa.recv_data), 32'(d));
                chk("a_mismatch_count", 32'(ifa.mismatch_count), mm_a);
            end
        end
        if (ifb.recv_valid === 1'b1) begin
            rcv_b++;
            got_b.push_back(ifb.recv_data);
            chk("b_recv_expected", 32'(qb_d.size() > 0), 1);
            if (qb_d.size() > 0) begin
                d = qb_d.pop_front();
                chk("b_recv_data", 32'(ifb.recv_data), 32'(d));
                chk("b_mismatch_count", 32'(ifb.mismatch_count), 0);
            end
        end
    end

    task automatic pulse_start(input int w);
        @(negedge clk);
        if (w == 0) ifa.start = 1'b1;
        else ifb.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        chk("busy_after_start", 32'((w == 0) ? ifa.busy : ifb.busy), 1);
        chk("done_cleared", 32'((w == 0) ? ifa.done : ifb.done), 0);
    endtask

    task automatic wait_done(input int w, input int maxc, output int n);
        n = 0;
        while (((w == 0) ? ifa.done : ifb.done) !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("done_within_bound", 32'((w == 0) ? ifa.done : ifb.done), 1);
    endtask

    // expected echoes for one run of A: bad flags per char from masks
    task automatic plan_a(input logic [15:0] fm, input logic [15:0] sm);
        logic [7:0] c;
        for (int i = 0; i < 10; i++) begin
            c = 8'h61 + 8'(i);
            if (fm[i]) c = c ^ 8'h01;
            qa_d.push_back(c);
            qa_b.push_back((fm[i] || sm[i]) ? 1 : 0);
        end
    endtask

    task automatic check_reset_a(input string tag);
        chk({tag, "_serial_out"}, 32'(ifa.serial_out), 1);
        chk({tag, "_busy"}, 32'(ifa.busy), 0);
        chk({tag, "_done"}, 32'(ifa.done), 0);
        chk({tag, "_pass"}, 32'(ifa.pass), 0);
        chk({tag, "_timeout"}, 32'(ifa.timeout), 0);
        chk({tag, "_mm"}, 32'(ifa.mismatch_count), 0);
        chk({tag, "_recv_valid"}, 32'(ifa.recv_valid), 0);
        chk({tag, "_recv_data"}, 32'(ifa.recv_data), 0);
    endtask

    task automatic check_end_a(input string tag, input int mm,
                               input logic p, input logic t);
        chk({tag, "_done"}, 32'(ifa.done), 1);
        chk({tag, "_busy"}, 32'(ifa.busy), 0);
        chk({tag, "_pass"}, 32'(ifa.pass), 32'(p));
        chk({tag, "_timeout"}, 32'(ifa.timeout), 32'(t));
        chk({tag, "_mm"}, 32'(ifa.mismatch_count), mm);
    endtask

    initial begin : main
        int n;
        int r0;
        int f0;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_a("rst");
        chk("rst_b_serial_out", 32'(ifb.serial_out), 1);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 4; i++) qb_d.push_back(8'hFE + 8'(i));
        pulse_start(1);
        wait_done(1, 8000, n);
        chk("b_pass", 32'(ifb.pass), 1);
        chk("b_timeout", 32'(ifb.timeout), 0);
        chk("b_mm", 32'(ifb.mismatch_count), 0);
        chk("b_frames", frames_b, 4);
        chk("b_nrecv", got_b.size(), 4);
        if (got_b.size() == 4) begin
            chk("b_char0", 32'(got_b[0]), 32'h0FE);
            chk("b_char1", 32'(got_b[1]), 32'h0FF);
            chk("b_char2", 32'(got_b[2]), 32'h000);
            chk("b_char3", 32'(got_b[3]), 32'h001);
        end

        mode = 1;
        mm_a = 0;
        plan_a('0, '0);
        pulse_start(0);
        wait_done(0, 5000, n);
        check_end_a("loop", 0, 1'b1, 1'b0);
        chk("loop_nrecv", rcv_a, 10);
        chk("loop_first", 32'(got_a[0]), 32'h061);
        chk("loop_last", 32'(got_a[9]), 32'h06A);

        mode = 0;
        drv_si = 1'b1;
        repeat (10) @(negedge clk);
        r0 = rcv_a;
        drv_si = 1'b0;
        repeat (5) @(negedge clk);
        drv_si = 1'b1;
        repeat (60) @(negedge clk);
        chk("glitch_no_recv", rcv_a, r0);

        mode = 2;
        echo_i = 0;
        flip_mask = 16'h0088;
        stop_mask = '0;
        mm_a = 0;
        got_a.delete();
        plan_a(flip_mask, stop_mask);
        pulse_start(0);
        wait_done(0, 8000, n);
        check_end_a("flip", 2, 1'b0, 1'b0);
        chk("flip_nrecv", got_a.size(), 10);
        if (got_a.size() == 10) begin
            chk("flip_char3", 32'(got_a[3]), 32'h065);
            chk("flip_char7", 32'(got_a[7]), 32'h069);
        end

        repeat (4 * B) @(negedge clk);
        echo_i = 0;
        flip_mask = '0;
        stop_mask = 16'h0004;
        mm_a = 0;
        got_a.delete();
        plan_a(flip_mask, stop_mask);
        pulse_start(0);
        wait_done(0, 8000, n);
        check_end_a("stopbit", 1, 1'b0, 1'b0);
        chk("stopbit_char2", 32'(got_a[2]), 32'h063);

        repeat (4 * B) @(negedge clk);
        mode = 0;
        drv_si = 1'b1;
        f0 = frames_a;
        r0 = rcv_a;
        pulse_start(0);
        wait_done(0, TO + 500, n);
        check_end_a("silent", 0, 1'b0, 1'b1);
        chk("silent_frames", frames_a - f0, 4);
        chk("silent_serial_out", 32'(ifa.serial_out), 1);
        chk("silent_time", 32'(n >= TO - 5 && n <= TO + 5), 1);
        chk("silent_no_recv", rcv_a, r0);

        mode = 1;
        mm_a = 0;
        qa_d.push_back(8'h61);
        qa_b.push_back(0);
        qa_d.push_back(8'h62);
        qa_b.push_back(0);
        pulse_start(0);
        repeat (408) @(negedge clk);
        chk("midrun_busy", 32'(ifa.busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_a("midrst");
        chk("midrst_pending", qa_d.size(), 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        mm_a = 0;
        plan_a('0, '0);
        pulse_start(0);
        wait_done(0, 5000, n);
        check_end_a("rerun", 0, 1'b1, 1'b0);
        chk("rerun_pending", qa_d.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_echo_agent.md
Name: uart_echo_agent

Overview:
Synthesizable host-side UART agent that transmits a programmable sequence of characters to a device's serial input. It receives the device's echoes, checks them against the sent characters, and reports pass/fail, mismatch count and timeout. It allows a bounded number of characters in flight, using an expected-character FIFO. It replaces hand-written serial tasks in CPU echo benches and can also run on-board as a self-test between two UART endpoints.

Parameters:
CLOCK_FREQ, 50_000_000, clk frequency in Hz
BAUD_RATE, 115_200, serial bit rate
NUM_CHARS, 10, characters per run (1..65535)
CHAR0, 8'h61, first character; char i = (CHAR0 + i) mod 256
INFLIGHT, 4, expected-FIFO depth = max sent-but-unechoed chars (power of 2, >=1)
GAP_BITS, 0, idle bit-times inserted after each TX stop bit
TIMEOUT_CYCLES, 100_000, max clk cycles FIFO may stay non-empty with no RX completion

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse begins a run; ignored while busy
serial_out  out  1  to device serial_in; idle high
serial_in  in  1  from device serial_out; idle high
busy  out  1  run in progress
done  out  1  sticky; run finished (all echoes checked or timeout); cleared by start
pass  out  1  valid when done: no mismatches and no timeout
timeout  out  1  sticky timeout flag; cleared by start
mismatch_count  out  16  saturating count of bad echoes
recv_valid  out  1  one-cycle pulse per received character
recv_data  out  8  last received payload; held between pulses

Behaviour:
- Reset: serial_out=1, busy=0, done=0, pass=0, timeout=0, mismatch_count=0, recv_valid=0, recv_data=0. The FIFO is emptied, all counters are cleared, and both FSMs go to IDLE. Reset mid-run aborts the run immediately, including a frame in progress.
- Bit period: B = CLOCK_FREQ/BAUD_RATE cycles (integer division). Frame = 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- Start accepted (busy=0):
  - next cycle busy=1; done, timeout, mismatch_count cleared; tx_idx=0, rx_idx=0.
- TX FSM: IDLE -> START -> DATA(8) -> STOP -> GAP -> IDLE.
  - In IDLE with busy and tx_idx<NUM_CHARS and FIFO not full: push char tx_idx into FIFO and enter START in the same cycle.
  - Each state holds serial_out for exactly B cycles; GAP holds 1 for GAP_BITS*B cycles and is skipped if GAP_BITS=0.
  - tx_idx increments on entering STOP.
  - If the FIFO is full, TX stays in IDLE with serial_out=1.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - serial_in passes through a 2-flop synchronizer before use.
  - IDLE: a low level moves to START.
  - START: serial_in is resampled at B/2; if high, it is a false start and RX returns to IDLE with no count.
  - DATA: each data bit is sampled B cycles after the previous sample point.
  - STOP: sampled at its midpoint. RX completes at that sample and returns to IDLE, which allows back-to-back frames.
- On RX completion:
  - recv_valid pulses and recv_data updates.
  - If the FIFO is non-empty: pop it and compare. The echo is bad if the payload differs or the stop bit is 0.
  - If the FIFO is empty: the character is unexpected; it is bad and nothing is popped.
  - A bad echo increments mismatch_count, saturating at 16'hFFFF.
  - rx_idx increments only on a pop.
- Simultaneous FIFO push and pop in one cycle are both honoured; occupancy is unchanged.
- Timeout counter:
  - counts while busy and the FIFO is non-empty.
  - clears on every RX completion and whenever the FIFO is empty.
  - reaching TIMEOUT_CYCLES sets timeout=1, done=1, pass=0, busy=0; TX and RX are aborted to IDLE with serial_out=1.
- Normal completion: when rx_idx==NUM_CHARS, next cycle busy=0, done=1, pass=(mismatch_count==0).
- Characters arriving while busy=0 are received (recv_valid pulses) but are not counted.

Test Plan:
- Loopback: serial_out wired to serial_in, defaults, start pulse → 10 recv_valid pulses with data 61..6A; done=1, pass=1, mismatch_count=0, timeout=0.
- Corrupting echo model (XOR bit 0 on chars 3 and 7) → recv_data 0x65 and 0x69 at those positions; mismatch_count=2, pass=0.
- serial_in tied high → exactly INFLIGHT=4 frames sent, then TX stalls idle. After TIMEOUT_CYCLES with no RX: timeout=1, done=1, pass=0, busy=0.
- Echo model with 6 char-times latency, INFLIGHT=2 → never more than 2 unechoed frames on serial_out; pass=1. CHAR0=8'hFE, NUM_CHARS=4 → sequence FE, FF, 00, 01.
- 0.3·B low glitch on serial_in while idle → no recv_valid. A frame with stop bit 0 → mismatch_count increments.
- rst asserted mid-frame (char 2, data bit 4) → next cycle serial_out=1 and all outputs at reset values. A new start then completes a clean run with pass=1.
